// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard controller.
//   hcu_state_e : controller FSM states (run / load-use wait / multi-cycle busy)
//   REG_ZERO    : architectural zero register address (x0), never a hazard source
//   hcu_hit     : load-use hazard compare between the EX load and the ID sources
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam int HCU_MAX_AW = 32;

    localparam logic [HCU_MAX_AW-1:0] REG_ZERO = 32'd0;

    typedef enum logic [1:0] {
        HCU_RUN       = 2'd0,
        HCU_LOAD_WAIT = 2'd1,
        HCU_MC_BUSY   = 2'd2
    } hcu_state_e;

    // Register addresses are zero-extended to HCU_MAX_AW by the caller so one
    // helper serves every REG_AW; writes to x0 are discarded and never hazard.
    function automatic logic hcu_hit(
        input logic                  mem_read,
        input logic [HCU_MAX_AW-1:0] rd,
        input logic [HCU_MAX_AW-1:0] rs1,
        input logic [HCU_MAX_AW-1:0] rs2,
        input logic                  use_rs1,
        input logic                  use_rs2
    );
        logic match_s;
        match_s = (use_rs1 && (rd == rs1)) || (use_rs2 && (rd == rs2));
        return mem_read && (rd != REG_ZERO) && match_s;
    endfunction

endpackage

// File: rtl/hcu_checker.sv
// -----------------------------------------------------------------------------
// hcu_checker
// Protocol checks on the hazard controller inputs.
// Ports:
//   clk, rst         clock, synchronous active-high reset (checks disabled in reset)
//   in_mc_busy       controller currently in its multi-cycle busy state
//   branch_taken     branch resolved taken in EX
//   mc_start         multi-cycle op entering EX
//   id_ex_mem_read   load in EX
// -----------------------------------------------------------------------------
module hcu_checker (
    input logic clk,
    input logic rst,
    input logic in_mc_busy,
    input logic branch_taken,
    input logic mc_start,
    input logic id_ex_mem_read
);

    // EX is frozen while a multi-cycle op runs, so no branch can resolve there.
    a_no_branch_in_mc_busy: assert property (
        @(posedge clk) disable iff (rst) !(in_mc_busy && branch_taken)
    );

    // A load and a multi-cycle op cannot occupy the same EX slot.
    a_no_mc_start_with_load: assert property (
        @(posedge clk) disable iff (rst) !(mc_start && id_ex_mem_read)
    );

endmodule

// File: rtl/hcu_perf_cnt.sv
// -----------------------------------------------------------------------------
// hcu_perf_cnt
// Three saturating event counters for the hazard controller.
// Ports:
//   clk, rst            clock, synchronous active-high clear
//   load_stall_inc      count one load-use bubble cycle
//   mc_stall_inc        count one multi-cycle hold cycle
//   flush_inc           count one branch flush
//   perf_load_stall / perf_mc_stall / perf_flush   counter values (CNT_W bits)
// Counters stick at all-ones instead of wrapping.
// -----------------------------------------------------------------------------
module hcu_perf_cnt #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_stall_inc,
    input  logic             mc_stall_inc,
    input  logic             flush_inc,
    output logic [CNT_W-1:0] perf_load_stall,
    output logic [CNT_W-1:0] perf_mc_stall,
    output logic [CNT_W-1:0] perf_flush
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
        logic [CNT_W-1:0] res_s;
        if (val == {CNT_W{1'b1}}) begin
            res_s = val;
        end else begin
            res_s = val + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return res_s;
    endfunction

    // Load-use bubble cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_load_stall <= {CNT_W{1'b0}};
        end else if (load_stall_inc) begin
            perf_load_stall <= sat_inc(perf_load_stall);
        end
    end

    // Multi-cycle hold cycle counter
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_mc_stall <= {CNT_W{1'b0}};
        end else if (mc_stall_inc) begin
            perf_mc_stall <= sat_inc(perf_mc_stall);
        end
    end

    // Branch flush event counter
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_flush <= {CNT_W{1'b0}};
        end else if (flush_inc) begin
            perf_flush <= sat_inc(perf_flush);
        end
    end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Pipeline hazard controller between the IF/ID and ID/EX registers of the
// 5-stage core: load-use stall (LOAD_LAT cycles), freeze during multi-cycle
// EX ops, and flush of younger stages on a taken branch.
// Parameters: REG_AW, LOAD_LAT (>=1), FLUSH_STAGES, CNT_W.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   id_ex_mem_read, id_ex_rd         load in EX and its destination
//   if_id_rs1/rs2, if_id_use_rs1/2   ID sources and whether they are read
//   branch_taken, mc_start, mc_done  EX events (single-cycle pulses)
//   pc_write, if_id_write            front-end enables
//   id_ex_bubble, ex_hold, stall     stall controls
//   flush                            per-stage clear (bit0 = IF/ID)
//   perf_load_stall/mc_stall/flush   event counters
// Optional feature macro: HCU_PERF_CNT_EN enables the saturating perf
// counters; without it the counter ports are tied to zero.
// Outputs are combinational from state and inputs.
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int LOAD_LAT     = 1,
    parameter int FLUSH_STAGES = 2,
    parameter int CNT_W        = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    id_ex_mem_read,
    input  logic [REG_AW-1:0]       id_ex_rd,
    input  logic [REG_AW-1:0]       if_id_rs1,
    input  logic [REG_AW-1:0]       if_id_rs2,
    input  logic                    if_id_use_rs1,
    input  logic                    if_id_use_rs2,
    input  logic                    branch_taken,
    input  logic                    mc_start,
    input  logic                    mc_done,
    output logic                    pc_write,
    output logic                    if_id_write,
    output logic                    id_ex_bubble,
    output logic                    ex_hold,
    output logic                    stall,
    output logic [FLUSH_STAGES-1:0] flush,
    output logic [CNT_W-1:0]        perf_load_stall,
    output logic [CNT_W-1:0]        perf_mc_stall,
    output logic [CNT_W-1:0]        perf_flush
);

    localparam int CW = $clog2(LOAD_LAT + 1);

    hcu_state_e    state_r;
    hcu_state_e    state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          hit_s;

    assign hit_s = hcu_hit(id_ex_mem_read,
                           HCU_MAX_AW'(id_ex_rd),
                           HCU_MAX_AW'(if_id_rs1),
                           HCU_MAX_AW'(if_id_rs2),
                           if_id_use_rs1,
                           if_id_use_rs2);

    // FSM state and load-wait counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= HCU_RUN;
            cnt_r   <= {CW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
        end
    end

    // Next-state and output decode; priority branch_taken > mc_start > hit
    always_comb begin
        state_nxt_s  = state_r;
        cnt_nxt_s    = cnt_r;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_bubble = 1'b0;
        ex_hold      = 1'b0;
        flush        = {FLUSH_STAGES{1'b0}};
        if (rst) begin
            // Outputs released during reset; the register resets state itself.
            state_nxt_s = HCU_RUN;
            cnt_nxt_s   = {CW{1'b0}};
        end else begin
            case (state_r)
                HCU_RUN: begin
                    if (branch_taken) begin
                        flush     = {FLUSH_STAGES{1'b1}};
                        cnt_nxt_s = {CW{1'b0}};
                    end else if (mc_start) begin
                        // The op only enters EX this cycle; hold starts next cycle.
                        state_nxt_s = HCU_MC_BUSY;
                    end else if (hit_s) begin
                        id_ex_bubble = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        if (LOAD_LAT > 1) begin
                            cnt_nxt_s   = CW'(LOAD_LAT - 1);
                            state_nxt_s = HCU_LOAD_WAIT;
                        end else begin
                            state_nxt_s = HCU_RUN;
                        end
                    end else begin
                        state_nxt_s = HCU_RUN;
                    end
                end
                HCU_LOAD_WAIT: begin
                    if (branch_taken) begin
                        flush       = {FLUSH_STAGES{1'b1}};
                        cnt_nxt_s   = {CW{1'b0}};
                        state_nxt_s = HCU_RUN;
                    end else begin
                        id_ex_bubble = 1'b1;
                        pc_write     = 1'b0;
                        if_id_write  = 1'b0;
                        cnt_nxt_s    = cnt_r - CW'(1);
                        if (cnt_r == CW'(1)) begin
                            state_nxt_s = HCU_RUN;
                        end else begin
                            state_nxt_s = HCU_LOAD_WAIT;
                        end
                    end
                end
                HCU_MC_BUSY: begin
                    // branch_taken cannot legally occur here and is ignored.
                    if (mc_done) begin
                        state_nxt_s = HCU_RUN;
                    end else begin
                        ex_hold     = 1'b1;
                        pc_write    = 1'b0;
                        if_id_write = 1'b0;
                    end
                end
                default: begin
                    state_nxt_s = HCU_RUN;
                    cnt_nxt_s   = {CW{1'b0}};
                end
            endcase
        end
    end

    assign stall = id_ex_bubble | ex_hold;

`ifdef HCU_PERF_CNT_EN
    hcu_perf_cnt #(
        .CNT_W (CNT_W)
    ) u_perf_cnt (
        .clk             (clk),
        .rst             (rst),
        .load_stall_inc  (id_ex_bubble),
        .mc_stall_inc    (ex_hold),
        .flush_inc       (|flush),
        .perf_load_stall (perf_load_stall),
        .perf_mc_stall   (perf_mc_stall),
        .perf_flush      (perf_flush)
    );
`else
    assign perf_load_stall = {CNT_W{1'b0}};
    assign perf_mc_stall   = {CNT_W{1'b0}};
    assign perf_flush      = {CNT_W{1'b0}};
`endif

    hcu_checker u_checker (
        .clk            (clk),
        .rst            (rst),
        .in_mc_busy     (state_r == HCU_MC_BUSY),
        .branch_taken   (branch_taken),
        .mc_start       (mc_start),
        .id_ex_mem_read (id_ex_mem_read)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Directed bench for hazard_ctrl_unit with LOAD_LAT=3, FLUSH_STAGES=2, CNT_W=4.
// Inputs change 1 time unit after the rising edge; outputs are checked on the
// falling edge. Output vector order: {pc_write, if_id_write, id_ex_bubble,
// ex_hold, stall, flush[1:0]}.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    localparam int REG_AW       = 5;
    localparam int LOAD_LAT     = 3;
    localparam int FLUSH_STAGES = 2;
    localparam int CNT_W        = 4;

    localparam logic [6:0] O_RUN   = 7'b1100000;
    localparam logic [6:0] O_BUB   = 7'b0010100;
    localparam logic [6:0] O_HOLD  = 7'b0001100;
    localparam logic [6:0] O_FLUSH = 7'b1100011;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    id_ex_mem_read;
    logic [REG_AW-1:0]       id_ex_rd;
    logic [REG_AW-1:0]       if_id_rs1;
    logic [REG_AW-1:0]       if_id_rs2;
    logic                    if_id_use_rs1;
    logic                    if_id_use_rs2;
    logic                    branch_taken;
    logic                    mc_start;
    logic                    mc_done;
    logic                    pc_write;
    logic                    if_id_write;
    logic                    id_ex_bubble;
    logic                    ex_hold;
    logic                    stall;
    logic [FLUSH_STAGES-1:0] flush;
    logic [CNT_W-1:0]        perf_load_stall;
    logic [CNT_W-1:0]        perf_mc_stall;
    logic [CNT_W-1:0]        perf_flush;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_ctrl_unit #(
        .REG_AW       (REG_AW),
        .LOAD_LAT     (LOAD_LAT),
        .FLUSH_STAGES (FLUSH_STAGES),
        .CNT_W        (CNT_W)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rd        (id_ex_rd),
        .if_id_rs1       (if_id_rs1),
        .if_id_rs2       (if_id_rs2),
        .if_id_use_rs1   (if_id_use_rs1),
        .if_id_use_rs2   (if_id_use_rs2),
        .branch_taken    (branch_taken),
        .mc_start        (mc_start),
        .mc_done         (mc_done),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_bubble    (id_ex_bubble),
        .ex_hold         (ex_hold),
        .stall           (stall),
        .flush           (flush),
        .perf_load_stall (perf_load_stall),
        .perf_mc_stall   (perf_mc_stall),
        .perf_flush      (perf_flush)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        rst            = 1'b0;
        id_ex_mem_read = 1'b0;
        id_ex_rd       = 5'd0;
        if_id_rs1      = 5'd0;
        if_id_rs2      = 5'd0;
        if_id_use_rs1  = 1'b0;
        if_id_use_rs2  = 1'b0;
        branch_taken   = 1'b0;
        mc_start       = 1'b0;
        mc_done        = 1'b0;
    endtask

    task automatic set_load(input logic rd_load, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic u1,
                            input logic [4:0] rs2, input logic u2);
        id_ex_mem_read = rd_load;
        id_ex_rd       = rd;
        if_id_rs1      = rs1;
        if_id_use_rs1  = u1;
        if_id_rs2      = rs2;
        if_id_use_rs2  = u2;
    endtask

    // Check the current cycle's outputs, then advance to just after the next edge.
    task automatic check_cycle(input string tag, input logic [6:0] exp);
        @(negedge clk);
        check_val(tag, {25'd0, pc_write, if_id_write, id_ex_bubble, ex_hold, stall, flush},
                  {25'd0, exp});
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst      = 1'b1;
        mc_start = 1'b1;
        tick();
        // Reset forces released outputs even with mc_start asserted.
        check_cycle("reset_outputs", O_RUN);
        @(negedge clk);
        check_val("reset_perf_load", {28'd0, perf_load_stall}, 32'd0);
        idle_inputs();
        tick();

        // Load-use on rs1: exactly LOAD_LAT bubble cycles, then RUN.
        set_load(1'b1, 5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
        check_cycle("lu_rs1_c0", O_BUB);
        id_ex_mem_read = 1'b0;
        check_cycle("lu_rs1_c1", O_BUB);
        check_cycle("lu_rs1_c2", O_BUB);
        check_cycle("lu_rs1_after", O_RUN);

        // x0 destination never hazards.
        set_load(1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
        check_cycle("lu_x0", O_RUN);
        // rs2 matches but is not read.
        set_load(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b0);
        check_cycle("lu_rs2_unused", O_RUN);
        // Match without a load in EX.
        set_load(1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b1);
        check_cycle("no_load_match", O_RUN);

        // Load-use on rs2, branch taken in stall cycle 2 aborts the wait.
        set_load(1'b1, 5'd7, 5'd3, 1'b1, 5'd7, 1'b1);
        check_cycle("lu_rs2_c0", O_BUB);
        idle_inputs();
        branch_taken = 1'b1;
        check_cycle("br_abort", O_FLUSH);
        branch_taken = 1'b0;
        check_cycle("br_abort_run", O_RUN);
        check_cycle("br_abort_run2", O_RUN);

        // Multi-cycle op: start at t0, done at t5.
        mc_start = 1'b1;
        check_cycle("mc_t0", O_RUN);
        mc_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            check_cycle($sformatf("mc_t%0d", i), O_HOLD);
        end
        mc_done = 1'b1;
        check_cycle("mc_t5_done", O_RUN);
        mc_done = 1'b0;
        check_cycle("mc_t6", O_RUN);

        // mc_start with mc_done in RUN: mc_done ignored, busy entered.
        mc_start = 1'b1;
        mc_done  = 1'b1;
        check_cycle("mc_both_t0", O_RUN);
        mc_start = 1'b0;
        mc_done  = 1'b0;
        check_cycle("mc_both_t1", O_HOLD);
        mc_done = 1'b1;
        check_cycle("mc_both_done", O_RUN);
        mc_done = 1'b0;

        // Branch beats a simultaneous load-use hit.
        set_load(1'b1, 5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
        branch_taken = 1'b1;
        check_cycle("br_over_hit", O_FLUSH);
        idle_inputs();
        check_cycle("br_over_hit_run", O_RUN);

        // Reset during multi-cycle busy.
        mc_start = 1'b1;
        check_cycle("rst_mc_t0", O_RUN);
        mc_start = 1'b0;
        check_cycle("rst_mc_t1", O_HOLD);
        rst = 1'b1;
        check_cycle("rst_mc_in_rst", O_RUN);
        rst = 1'b0;
        check_cycle("rst_mc_after", O_RUN);
        mc_done = 1'b1;
        check_cycle("rst_mc_late_done", O_RUN);
        mc_done = 1'b0;
        check_cycle("rst_mc_idle", O_RUN);

        // Perf counters: reset, then 7 load-use hazards = 21 bubble cycles.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int h = 0; h < 7; h++) begin
            set_load(1'b1, 5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
            tick();
            id_ex_mem_read = 1'b0;
            tick();
            tick();
        end
        idle_inputs();
        @(negedge clk);
`ifdef HCU_PERF_CNT_EN
        check_val("perf_load_sat", {28'd0, perf_load_stall}, 32'd15);
`else
        check_val("perf_load_tied", {28'd0, perf_load_stall}, 32'd0);
`endif
        check_val("perf_mc_zero", {28'd0, perf_mc_stall}, 32'd0);
        check_val("perf_flush_zero", {28'd0, perf_flush}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
